// File: rtl/approx_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : approx_mult_pkg
// Purpose  : Shared defaults and width helpers for the pipelined approximate
//            multiplier and its carry-free merge adder.
// Contents : c_def_width, c_def_approx_cols, c_cnt_width,
//            half_width(), prod_width()
// Revision : 1.0 - initial parametrised pipelined release
// ============================================================================
package approx_mult_pkg;

    // Default operand width and number of carry-free result columns.
    localparam int unsigned c_def_width       = 8;
    localparam int unsigned c_def_approx_cols = 6;

    // Width of the optional error-statistics counters.
    localparam int unsigned c_cnt_width = 32;

    // Split point of the multiplier operand b into two half layers.
    function automatic int unsigned half_width(input int unsigned width);
        return width / 2;
    endfunction

    // Full product width for a width x width multiply.
    function automatic int unsigned prod_width(input int unsigned width);
        return 2 * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_mult_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : approx_mult_pipe_if
// Purpose  : Operand / result handshake bundle of approx_mult_pipe.
// Signals  : in_valid/in_ready/in_a/in_b/in_approx   operand beat
//            out_valid/out_ready/out_p/out_approx    result beat
// Modports : master - producer/consumer side (drives operands, out_ready)
//            slave  - multiplier side (drives in_ready and results)
// Revision : 1.0 - initial parametrised pipelined release
// ============================================================================
interface approx_mult_pipe_if #(
    parameter int unsigned WIDTH = approx_mult_pkg::c_def_width
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_approx;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic                 out_approx;

    modport master (
        output in_valid, in_a, in_b, in_approx, out_ready,
        input  in_ready, out_valid, out_p, out_approx
    );

    modport slave (
        input  in_valid, in_a, in_b, in_approx, out_ready,
        output in_ready, out_valid, out_p, out_approx
    );

endinterface
`default_nettype wire

// File: rtl/approx_merge.sv
`default_nettype none
// ============================================================================
// Module   : approx_merge
// Purpose  : Combinational merge of two partial-product layers. In exact mode
//            the result is i_x + i_y. In approximate mode the low APPROX_COLS
//            columns are ORed (no carry generated) and the upper columns are
//            added on their own, truncated to the product width.
// Ports    : i_x, i_y  [2*WIDTH-1:0]  partial-product layers
//            i_approx                 1 = approximate merge
//            o_p       [2*WIDTH-1:0]  merged result
// Revision : 1.0 - initial parametrised pipelined release
// ============================================================================
module approx_merge #(
    parameter int unsigned WIDTH       = approx_mult_pkg::c_def_width,
    parameter int unsigned APPROX_COLS = approx_mult_pkg::c_def_approx_cols
) (
    input  wire logic [2*WIDTH-1:0] i_x,
    input  wire logic [2*WIDTH-1:0] i_y,
    input  wire logic               i_approx,
    output logic      [2*WIDTH-1:0] o_p
);
    import approx_mult_pkg::*;

    localparam int unsigned c_pw = prod_width(WIDTH);
    localparam int unsigned c_k  = APPROX_COLS;

    logic [c_pw-1:0] w_exact;
    assign w_exact = i_x + i_y;

    generate
        if (c_k == 0) begin : g_exact_only
            // No carry-free columns: the mode bit has no effect.
            logic w_unused_approx;
            assign w_unused_approx = i_approx;
            assign o_p = w_exact;
        end else if (c_k >= c_pw) begin : g_full_or
            assign o_p = i_approx ? (i_x | i_y) : w_exact;
        end else begin : g_split
            logic [c_k-1:0]      w_lo;
            logic [c_pw-c_k-1:0] w_hi;
            // Low columns never produce a carry into the upper adder.
            assign w_lo = i_x[c_k-1:0] | i_y[c_k-1:0];
            assign w_hi = i_x[c_pw-1:c_k] + i_y[c_pw-1:c_k];
            assign o_p  = i_approx ? {w_hi, w_lo} : w_exact;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : approx_mult_pipe
// Purpose  : Three-stage pipelined unsigned WIDTH x WIDTH multiplier with a
//            per-beat exact/approximate merge of its two half layers.
//              S1: operands and mode
//              S2: X = a*b_lo, Y = (a*b_hi) << WIDTH/2, mode
//              S3: merged product P (drives out_p / out_approx)
//            The whole pipe advances when the output register is empty or
//            being consumed; otherwise every stage holds.
// Ports    : clk, rst_n (synchronous, active low)
//            bus  approx_mult_pipe_if.slave operand/result handshakes
//            err_cnt, tot_cnt, max_err  (only with APPROX_MULT_ERR_STAT_EN)
// Options  : `define APPROX_MULT_ERR_STAT_EN adds result error statistics.
// Revision : 1.0 - initial parametrised pipelined release
// ============================================================================
module approx_mult_pipe #(
    parameter int unsigned WIDTH       = approx_mult_pkg::c_def_width,
    parameter int unsigned APPROX_COLS = approx_mult_pkg::c_def_approx_cols
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    approx_mult_pipe_if.slave     bus
`ifdef APPROX_MULT_ERR_STAT_EN
    ,
    output logic [approx_mult_pkg::c_cnt_width-1:0] err_cnt,
    output logic [approx_mult_pkg::c_cnt_width-1:0] tot_cnt,
    output logic [2*WIDTH-1:0]                      max_err
`endif
);
    import approx_mult_pkg::*;

    localparam int unsigned c_h  = half_width(WIDTH);
    localparam int unsigned c_pw = prod_width(WIDTH);

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic w_advance;

    logic r_s1_valid;
    logic r_s2_valid;
    logic r_s3_valid;

    // The output register frees up when empty or consumed this cycle; since
    // all stages move together that is the only condition for advancing.
    assign w_advance    = !r_s3_valid || bus.out_ready;
    assign bus.in_ready = w_advance;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_approx;

    logic [c_pw-1:0]  r_s2_x;
    logic [c_pw-1:0]  r_s2_y;
    logic             r_s2_approx;

    logic [c_pw-1:0]  r_s3_p;
    logic             r_s3_approx;

    logic [c_pw-1:0]  w_x;
    logic [c_pw-1:0]  w_y;
    logic [c_pw-1:0]  w_merge_p;

    // Both layers are widened before multiplying so no bits are lost; Y is
    // bounded by 2^(WIDTH+H) before the shift, so it always fits c_pw bits.
    assign w_x = c_pw'(r_s1_a) * c_pw'(r_s1_b[c_h-1:0]);
    assign w_y = (c_pw'(r_s1_a) * c_pw'(r_s1_b[WIDTH-1:c_h])) << c_h;

    approx_merge #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (APPROX_COLS)
    ) u_merge (
        .i_x      (r_s2_x),
        .i_y      (r_s2_y),
        .i_approx (r_s2_approx),
        .o_p      (w_merge_p)
    );

    // Valid bits and output-facing registers (reset).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_s3_p      <= '0;
            r_s3_approx <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= bus.in_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            // Keep the last result on the outputs when a bubble arrives.
            if (r_s2_valid) begin
                r_s3_p      <= w_merge_p;
                r_s3_approx <= r_s2_approx;
            end
        end
    end

    // Internal data stages carry no reset; their contents are qualified
    // by the stage valid bits.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_s1_a      <= bus.in_a;
            r_s1_b      <= bus.in_b;
            r_s1_approx <= bus.in_approx;
            r_s2_x      <= w_x;
            r_s2_y      <= w_y;
            r_s2_approx <= r_s1_approx;
        end
    end

    assign bus.out_valid  = r_s3_valid;
    assign bus.out_p      = r_s3_p;
    assign bus.out_approx = r_s3_approx;

`ifdef APPROX_MULT_ERR_STAT_EN
    // ------------------------------------------------------------------
    // Error statistics: the exact sum travels alongside the datapath.
    // ------------------------------------------------------------------
    logic [c_pw-1:0]        r_s2_exact;
    logic [c_pw-1:0]        r_s3_exact;
    logic [c_cnt_width-1:0] r_err_cnt;
    logic [c_cnt_width-1:0] r_tot_cnt;
    logic [c_pw-1:0]        r_max_err;
    logic                   w_out_hs;
    logic [c_pw-1:0]        w_err;

    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_s2_exact <= w_x + w_y;
            if (r_s2_valid) begin
                r_s3_exact <= r_s2_exact;
            end
        end
    end

    assign w_out_hs = r_s3_valid && bus.out_ready;
    // The carry-free merge can only drop value, so this never wraps.
    assign w_err    = r_s3_exact - r_s3_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
            r_tot_cnt <= '0;
            r_max_err <= '0;
        end else if (w_out_hs) begin
            if (r_tot_cnt != '1) begin
                r_tot_cnt <= r_tot_cnt + 1'b1;
            end
            if (r_s3_approx && (r_s3_p != r_s3_exact)) begin
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (w_err > r_max_err) begin
                    r_max_err <= w_err;
                end
            end
        end
    end

    assign err_cnt = r_err_cnt;
    assign tot_cnt = r_tot_cnt;
    assign max_err = r_max_err;
`endif

endmodule
`default_nettype wire

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
- Parametrised, pipelined successor to the team's LUT-level 8x8 approximate multiplier.
- Computes an unsigned WIDTH x WIDTH product as two half-multiplier layers (low and high halves of b), merged by an adder whose low APPROX_COLS columns are carry-free (OR).
- Per-transaction exact/approximate mode, valid/ready handshake on both sides, full back-pressure.
- Sits between operand producers and accumulator/filter datapaths.

Parameters:
- WIDTH, 8, operand width; even, 4..32.
- APPROX_COLS, 6, number of low result columns merged carry-free in approximate mode; 0..2*WIDTH (0 = always exact).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  WIDTH  multiplicand, unsigned
- in_b  in  WIDTH  multiplier, unsigned
- in_approx  in  1  1 = approximate merge, 0 = exact
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_p  out  2*WIDTH  product
- out_approx  out  1  echo of in_approx for this result

Behaviour:
- Reset (rst_n low at a clk edge): all stage valid bits cleared. out_valid=0, out_p=0, out_approx=0. Data registers need not be cleared except where they drive outputs. Reset mid-operation discards all in-flight beats.
- H = WIDTH/2. Layer products:
  - X = in_a * in_b[H-1:0]
  - Y = (in_a * in_b[WIDTH-1:H]) << H
  - Both are 2*WIDTH bits, zero-extended.
- Exact mode: P = X + Y, modulo 2^(2*WIDTH).
- Approximate mode, K = APPROX_COLS:
  - P[K-1:0] = X[K-1:0] | Y[K-1:0].
  - P[2W-1:K] = X[2W-1:K] + Y[2W-1:K], truncated.
  - No carry from the low region.
  - If K = 2*WIDTH, P = X | Y.
- Pipeline has three register stages:
  - S1: operands and mode.
  - S2: X, Y and mode.
  - S3: P, which drives out_p and out_approx.
- Latency: 3 cycles from the accepting edge (in_valid & in_ready) to out_valid, with no stall.
- Stall rule: advance = !out_valid | out_ready; in_ready = advance.
  - When advance = 0, every stage holds.
  - When advance = 1, every stage shifts, and empty stages shift bubbles.
- Throughput is 1 beat/cycle while out_ready = 1.
- out_p and out_approx are stable while out_valid & !out_ready.
- in_ready is combinational from out_valid and out_ready only; it does not depend on in_valid.
- A beat presented while in_ready = 0 is not taken. The source holds it.
- Simultaneous accept and output on the same edge is legal and loses no beat.

Optional Feature:
- Macro APPROX_MULT_ERR_STAT_EN.
- Defined:
  - Each stage also carries the exact sum.
  - Adds outputs err_cnt (32 bits), tot_cnt (32 bits) and max_err (2*WIDTH bits).
  - On each result handshake (out_valid & out_ready): tot_cnt increments.
  - If the result is approximate and P != exact: err_cnt increments and max_err updates to max(max_err, exact - P).
  - Counters saturate at all-ones.
  - All three clear on reset.
- Undefined: the ports and logic are absent, and datapath behaviour is identical.

Decomposition:
- Package approx_mult_pkg holds:
  - the default WIDTH and APPROX_COLS;
  - localparam helpers: half width, product width;
  - the counter width constant (32).
- Sub-module approx_merge is purely combinational: inputs X, Y and approx; output P; parametrised by WIDTH and APPROX_COLS. It is instantiated in S3 and can be reused by other approximate adders.
- The pipeline control (stage valids, advance) stays in approx_mult_pipe.

Test Plan:
- WIDTH=8, K=6, a=0xFF, b=0xFF, approx=1 -> out_p=0xFDF1 at cycle 3 after accept; same with approx=0 -> 0xFE01.
- a=0x0F, b=0x0F, approx=1 -> 0x00E1 (Y=0, exact). a=0, b=0xAB -> 0x0000.
- Back-to-back stream of 8 beats with out_ready held 0 for cycles 4-7 -> in_ready drops with the output stalled, no beat lost or duplicated, order preserved, out_p stable during the stall.
- rst_n low for 1 cycle with 3 beats in flight -> out_valid=0 the next cycle, no stale result ever emitted, next accepted beat emerges after 3 cycles.
- K=0 build, 1000 random beats with approx=1 -> every out_p equals a*b; K=16 build, a=0xFF, b=0xFF -> 0xEFF1 (X|Y).
- APPROX_MULT_ERR_STAT_EN, the 0xFF*0xFF approx beat then 0x0F*0x0F approx beat -> tot_cnt=2, err_cnt=1, max_err=0x0010.
